// File: rtl/mem_arbiter.sv
// Arbitrates IFU/LSU onto one 1-cycle data-memory port; LSU priority with IFU starvation bound.
// Latency: read rsp 3 cycles after accept, write ack 2, misaligned error 1.
// Backpressure: rsp_valid holds until rsp_ready; no new request is accepted until then.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [63:0] ifu_addr,
    output logic        ifu_rsp_valid,
    input  logic        ifu_rsp_ready,
    output logic [63:0] ifu_rdata,
    output logic        ifu_rsp_err,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic        lsu_wen,
    input  logic [63:0] lsu_addr,
    input  logic [63:0] lsu_wdata,
    input  logic [1:0]  lsu_wdt,
    output logic        lsu_rsp_valid,
    input  logic        lsu_rsp_ready,
    output logic [63:0] lsu_rdata,
    output logic        lsu_rsp_err,
    output logic [63:0] mem_raddr,
    output logic [63:0] mem_waddr,
    output logic [63:0] mem_wdata,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [1:0]  wdt_op,
    input  logic [63:0] mem_rdata
);
    // Width encoding: 0 = 8b, 1 = 16b, 2 = 32b, 3 = 64b
    localparam logic [1:0] WDT8  = 2'd0;
    localparam logic [1:0] WDT16 = 2'd1;
    localparam logic [1:0] WDT32 = 2'd2;
    localparam logic [1:0] WDT64 = 2'd3;

    typedef enum logic [1:0] {IDLE, ISSUE, DATA, RESP} state_t;

    state_t             state;
    logic               owner_lsu;
    logic               wen_q;
    logic               err_q;
    logic [63:0]        addr_q;
    logic [63:0]        wdata_q;
    logic [63:0]        rdata_q;
    logic [1:0]         wdt_q;
    logic [CNT_W-1:0]   streak;

    logic               starved;
    logic               grant_lsu;
    logic               grant_ifu;
    logic               idle;
    logic               in_resp;
    logic               req_mis;
    logic [63:0]        req_addr;
    logic [1:0]         req_wdt;
    logic               owner_rsp_ready;

    function automatic logic misaligned(input logic [1:0] wdt, input logic [2:0] a);
        case (wdt)
            WDT8:    misaligned = 1'b0;
            WDT16:   misaligned = a[0];
            WDT32:   misaligned = |a[1:0];
            default: misaligned = |a[2:0];
        endcase
    endfunction

    assign starved   = (streak == CNT_W'(STARVE_LIMIT));
    assign grant_lsu = lsu_req_valid && !(ifu_req_valid && starved);
    assign grant_ifu = ifu_req_valid && !grant_lsu;
    assign idle      = (state == IDLE);
    assign in_resp   = (state == RESP);

    assign lsu_req_ready = idle && grant_lsu;
    assign ifu_req_ready = idle && grant_ifu;

    // Fetches are always word accesses regardless of what the LSU presents
    assign req_addr = grant_lsu ? lsu_addr : ifu_addr;
    assign req_wdt  = grant_lsu ? lsu_wdt  : WDT32;
    assign req_mis  = misaligned(req_wdt, req_addr[2:0]);

    assign owner_rsp_ready = owner_lsu ? lsu_rsp_ready : ifu_rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner_lsu <= 1'b0;
            wen_q     <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            wdt_q     <= WDT8;
            streak    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_lsu || grant_ifu) begin
                        owner_lsu <= grant_lsu;
                        addr_q    <= req_addr;
                        wdata_q   <= grant_lsu ? lsu_wdata : 64'd0;
                        wdt_q     <= req_wdt;
                        wen_q     <= grant_lsu && lsu_wen;
                        err_q     <= req_mis;
                        rdata_q   <= '0;
                        state     <= req_mis ? RESP : ISSUE;
                        if (grant_lsu && ifu_req_valid) begin
                            if (!starved)
                                streak <= streak + 1'b1;
                        end else begin
                            streak <= '0;
                        end
                    end
                end
                ISSUE:   state <= wen_q ? RESP : DATA;
                DATA: begin
                    rdata_q <= mem_rdata;
                    state   <= RESP;
                end
                default: if (owner_rsp_ready) state <= IDLE;
            endcase
        end
    end

    assign mem_ren   = (state == ISSUE) && !wen_q;
    assign mem_wen   = (state == ISSUE) &&  wen_q;
    assign mem_raddr = addr_q;
    assign mem_waddr = addr_q;
    assign mem_wdata = wdata_q;
    assign wdt_op    = wdt_q;

    assign ifu_rsp_valid = in_resp && !owner_lsu;
    assign lsu_rsp_valid = in_resp &&  owner_lsu;
    assign ifu_rsp_err   = in_resp && !owner_lsu && err_q;
    assign lsu_rsp_err   = in_resp &&  owner_lsu && err_q;
    assign ifu_rdata     = owner_lsu ? 64'd0 : rdata_q;
    assign lsu_rdata     = owner_lsu ? rdata_q : 64'd0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle memory model and strobe counters.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
    logic [63:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_ready, lsu_rsp_err;
    logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [1:0]  lsu_wdt, wdt_op;
    logic [63:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
    logic        mem_ren, mem_wen;

    logic [63:0] mem_word;
    int          ren_cnt = 0;
    int          wen_cnt = 0;
    int          errors = 0;
    int          checks = 0;

    mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rdata(ifu_rdata),
        .ifu_rsp_err(ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wdt(lsu_wdt),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rdata(lsu_rdata),
        .lsu_rsp_err(lsu_rsp_err),
        .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .wdt_op(wdt_op), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory returns mem_word the cycle after a read strobe, zero otherwise
    always @(posedge clk) begin
        mem_rdata <= mem_ren ? mem_word : 64'd0;
        if (mem_ren) ren_cnt <= ren_cnt + 1;
        if (mem_wen) wen_cnt <= wen_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here, outputs checked #1 later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int r0, w0, n, got_ifu;
        logic [63:0] held;

        rst = 1'b1;
        ifu_req_valid = 0; ifu_addr = 0; ifu_rsp_ready = 1;
        lsu_req_valid = 0; lsu_wen = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wdt = 0; lsu_rsp_ready = 1;
        mem_word = 0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_ifu_rdy", {63'd0, ifu_req_ready}, 64'd0);
        check("rst_rsp_vld", {62'd0, ifu_rsp_valid, lsu_rsp_valid}, 64'd0);
        check("rst_strobes", {62'd0, mem_ren, mem_wen}, 64'd0);
        check("rst_raddr", mem_raddr, 64'd0);
        check("rst_wdata", mem_wdata, 64'd0);
        check("rst_wdt", {62'd0, wdt_op}, 64'd0);
        check("rst_err", {62'd0, ifu_rsp_err, lsu_rsp_err}, 64'd0);

        // Single IFU read
        tick();
        ifu_req_valid = 1; ifu_addr = 64'h8000_0004; mem_word = 64'hDEAD_BEEF;
        #1;
        check("rd_c0_ifu_rdy", {63'd0, ifu_req_ready}, 64'd1);
        check("rd_c0_lsu_rdy", {63'd0, lsu_req_ready}, 64'd0);
        tick(); ifu_req_valid = 0; #1;
        check("rd_c1_ren", {62'd0, mem_ren, mem_wen}, 64'd2);
        check("rd_c1_raddr", mem_raddr, 64'h8000_0004);
        check("rd_c1_wdt", {62'd0, wdt_op}, 64'd2);
        tick(); #1;
        check("rd_c2_vld", {63'd0, ifu_rsp_valid}, 64'd0);
        check("rd_c2_ren", {63'd0, mem_ren}, 64'd0);
        tick(); #1;
        check("rd_c3_vld", {63'd0, ifu_rsp_valid}, 64'd1);
        check("rd_c3_data", ifu_rdata, 64'hDEAD_BEEF);
        check("rd_c3_err", {63'd0, ifu_rsp_err}, 64'd0);
        tick(); #1;
        check("rd_c4_vld", {63'd0, ifu_rsp_valid}, 64'd0);

        // LSU byte store
        r0 = ren_cnt; w0 = wen_cnt;
        lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 64'h8000_0013; lsu_wdata = 64'hAB; lsu_wdt = 2'd0;
        #1;
        check("st_c0_lsu_rdy", {63'd0, lsu_req_ready}, 64'd1);
        tick(); lsu_req_valid = 0; #1;
        check("st_c1_strobes", {62'd0, mem_ren, mem_wen}, 64'd1);
        check("st_c1_waddr", mem_waddr, 64'h8000_0013);
        check("st_c1_wdata", mem_wdata, 64'hAB);
        check("st_c1_wdt", {62'd0, wdt_op}, 64'd0);
        check("st_c1_vld", {63'd0, lsu_rsp_valid}, 64'd0);
        tick(); #1;
        check("st_c2_ack", {63'd0, lsu_rsp_valid}, 64'd1);
        check("st_c2_err", {63'd0, lsu_rsp_err}, 64'd0);
        tick(); #1;
        check("st_wen_count", 64'(wen_cnt - w0), 64'd1);
        check("st_ren_count", 64'(ren_cnt - r0), 64'd0);

        // Misaligned LSU 64-bit load, then misaligned IFU fetch
        r0 = ren_cnt; w0 = wen_cnt;
        lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 64'h8000_0004; lsu_wdt = 2'd3;
        #1;
        check("mis_lsu_rdy", {63'd0, lsu_req_ready}, 64'd1);
        tick(); lsu_req_valid = 0; #1;
        check("mis_lsu_vld_err", {62'd0, lsu_rsp_valid, lsu_rsp_err}, 64'd3);
        check("mis_lsu_rdata", lsu_rdata, 64'd0);
        check("mis_lsu_strobe", {62'd0, mem_ren, mem_wen}, 64'd0);
        tick();
        ifu_req_valid = 1; ifu_addr = 64'h8000_0002;
        #1;
        check("mis_ifu_rdy", {63'd0, ifu_req_ready}, 64'd1);
        tick(); ifu_req_valid = 0; #1;
        check("mis_ifu_vld_err", {62'd0, ifu_rsp_valid, ifu_rsp_err}, 64'd3);
        check("mis_ifu_rdata", ifu_rdata, 64'd0);
        tick(); tick(); #1;
        check("mis_strobe_count", 64'(ren_cnt - r0 + wen_cnt - w0), 64'd0);

        // Starvation: both valid continuously, expect L L L L I repeating
        ifu_req_valid = 1; ifu_addr = 64'h8000_0000;
        lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 64'h8000_0008; lsu_wdt = 2'd3;
        mem_word = 64'h1;
        #1;
        for (int g = 0; g < 10; g++) begin
            n = 0;
            while (!(ifu_req_ready || lsu_req_ready) && n < 20) begin
                tick(); #1;
                n++;
            end
            got_ifu = ifu_req_ready ? 1 : 0;
            check($sformatf("starve_grant%0d", g), {62'd0, ifu_req_ready, lsu_req_ready},
                  (g % 5 == 4) ? 64'd2 : 64'd1);
            tick(); #1;
        end
        ifu_req_valid = 0; lsu_req_valid = 0;
        tick(); tick(); tick(); tick(); #1;
        check("starve_drained", {62'd0, ifu_rsp_valid, lsu_rsp_valid}, 64'd0);

        // Backpressure on an LSU load while IFU waits
        lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 64'h8000_0010; lsu_wdt = 2'd2;
        lsu_rsp_ready = 0; mem_word = 64'h1234_5678_9ABC_DEF0;
        #1;
        check("bp_c0_lsu_rdy", {63'd0, lsu_req_ready}, 64'd1);
        tick(); lsu_req_valid = 0; ifu_req_valid = 1; ifu_addr = 64'h8000_0040;
        tick(); tick(); #1;
        held = lsu_rdata;
        check("bp_c3_data", lsu_rdata, 64'h1234_5678_9ABC_DEF0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_hold%0d", i), {61'd0, lsu_rsp_valid, ifu_req_ready, ifu_rsp_valid},
                  64'd4);
            check($sformatf("bp_data%0d", i), lsu_rdata, held);
            tick(); #1;
        end
        lsu_rsp_ready = 1;
        #1;
        check("bp_release_vld", {62'd0, lsu_rsp_valid, ifu_req_ready}, 64'd2);
        tick(); #1;
        check("bp_ifu_granted", {62'd0, ifu_req_ready, lsu_rsp_valid}, 64'd2);
        tick(); ifu_req_valid = 0;
        tick(); tick(); tick(); #1;

        // Reset while in DATA
        lsu_req_valid = 1; lsu_addr = 64'h8000_0020; lsu_wdt = 2'd3; mem_word = 64'h5555;
        #1;
        check("rstm_c0_rdy", {63'd0, lsu_req_ready}, 64'd1);
        tick(); lsu_req_valid = 0;
        tick(); rst = 1;
        tick(); rst = 0; #1;
        check("rstm_strobes", {62'd0, mem_ren, mem_wen}, 64'd0);
        check("rstm_vld", {62'd0, lsu_rsp_valid, ifu_rsp_valid}, 64'd0);
        check("rstm_raddr", mem_raddr, 64'd0);
        check("rstm_rdata", lsu_rdata, 64'd0);
        check("rstm_wdt", {62'd0, wdt_op}, 64'd0);
        tick(); #1;
        check("rstm_no_rsp", {62'd0, lsu_rsp_valid, mem_ren}, 64'd0);
        ifu_req_valid = 1; ifu_addr = 64'h8000_0008; mem_word = 64'hCAFE_F00D;
        #1;
        check("rstm_new_rdy", {63'd0, ifu_req_ready}, 64'd1);
        tick(); ifu_req_valid = 0; #1;
        check("rstm_new_ren", {63'd0, mem_ren}, 64'd1);
        tick(); tick(); #1;
        check("rstm_new_vld", {63'd0, ifu_rsp_valid}, 64'd1);
        check("rstm_new_data", ifu_rdata, 64'hCAFE_F00D);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
